// File: rtl/axis_meta_egress.sv
// AXI4-Stream egress stage: queues per-frame parser metadata and releases each
// frame only once its record is available, forwarding or discarding it.
package axis_meta_egress_pkg;
    typedef struct packed {
        logic [15:0] ethertype;
        logic [11:0] vlan_id;
        logic [2:0]  pcp;
        logic        is_vlan;
    } eth_metadata_t;
endpackage

module axis_meta_egress
    import axis_meta_egress_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int META_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  eth_metadata_t         meta_in,
    input  logic                  meta_valid_in,
    input  logic                  meta_drop_in,
    output logic                  meta_full,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output eth_metadata_t         m_meta,
    output logic                  m_meta_valid,
    output logic                  meta_overflow,
    output logic [15:0]           drop_count
);
    localparam int PTR_W = $clog2(META_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

    typedef struct packed {
        eth_metadata_t meta;
        logic          drop;
    } entry_t;

    entry_t             fifo_mem [META_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_full, fifo_empty;
    logic               push, pop, overflow_set;

    state_e             state_q, state_d;
    eth_metadata_t      cur_meta_q, cur_meta_d;
    logic               s_ready, accept, load, drop_done;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  m_valid_q, m_valid_d;
    eth_metadata_t         out_meta_q, out_meta_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    // ---------------- metadata FIFO ----------------
    assign fifo_full    = (count_q == CNT_W'(META_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign head         = fifo_mem[rd_ptr_q];
    assign pop          = (state_q == IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push         = meta_valid_in && (!fifo_full || pop);
    assign overflow_set = meta_valid_in && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = overflow_q | overflow_set;
        cur_meta_d = pop ? head.meta : cur_meta_q;
    end

    // NOTE: storage arrays carry no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{meta: meta_in, drop: meta_drop_in};
        end
    end

    // ---------------- frame FSM ----------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = head.drop ? DROP : PASS;
                end
            end
            PASS: begin
                s_ready = !m_valid_q || m_axis_tready;
                if (s_axis_tvalid && s_ready && s_axis_tlast) state_d = IDLE;
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = s_axis_tvalid && s_ready;
    assign load      = accept && (state_q == PASS);
    assign drop_done = accept && (state_q == DROP) && s_axis_tlast;

    // ---------------- output slice ----------------
    always_comb begin
        m_valid_d  = m_valid_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        out_meta_d = out_meta_q;
        if (load) begin
            m_valid_d  = 1'b1;
            data_d     = s_axis_tdata;
            keep_d     = s_axis_tkeep;
            last_d     = s_axis_tlast;
            out_meta_d = cur_meta_q;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        drop_cnt_d = (drop_done && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cur_meta_q <= '0;
            m_valid_q  <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            out_meta_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cur_meta_q <= cur_meta_d;
            m_valid_q  <= m_valid_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            out_meta_q <= out_meta_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign meta_full     = fifo_full;
    assign meta_overflow = overflow_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_meta_valid  = m_valid_q;
    assign m_meta        = out_meta_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_axis_meta_egress.sv
// Directed bench for axis_meta_egress: gating, pass/drop, FIFO overflow,
// output stalls and mid-frame reset, with hand-computed expectations.
module tb_axis_meta_egress;
    import axis_meta_egress_pkg::*;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    eth_metadata_t meta_in;
    logic          meta_valid_in;
    logic          meta_drop_in;
    logic          meta_full;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    eth_metadata_t m_meta;
    logic          m_meta_valid;
    logic          meta_overflow;
    logic [15:0]   drop_count;

    int errors = 0;
    int checks = 0;

    axis_meta_egress #(.DATA_WIDTH(DW), .META_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .meta_in(meta_in), .meta_valid_in(meta_valid_in), .meta_drop_in(meta_drop_in),
        .meta_full(meta_full),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_meta(m_meta), .m_meta_valid(m_meta_valid),
        .meta_overflow(meta_overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input eth_metadata_t m, input logic drop);
        meta_in       = m;
        meta_drop_in  = drop;
        meta_valid_in = 1'b1;
        step();
        meta_valid_in = 1'b0;
        meta_drop_in  = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        #1;
        while (!s_axis_tready && n < 30) begin
            step();
            n++;
        end
        if (!s_axis_tready) check({tag, "_timeout"}, 64'(s_axis_tready), 64'd1);
    endtask

    // One-beat frame; checks the beat appears on the slice one cycle after acceptance.
    task automatic send1(input logic [63:0] d, input eth_metadata_t m, input string tag);
        s_axis_tdata  = d;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        wait_ready(tag);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check({tag, "_valid"}, 64'(m_axis_tvalid), 64'd1);
        check({tag, "_data"},  m_axis_tdata, d);
        check({tag, "_meta"},  64'(m_meta), 64'(m));
        check({tag, "_last"},  64'(m_axis_tlast), 64'd1);
    endtask

    eth_metadata_t mA, mA2, mB, mC, mD, mE, mF, mG, mH, mX, mB2, mR0, mR1, mR2, mN;
    eth_metadata_t m5 [4];
    logic [63:0]   d5 [4];
    logic [23:0]   pat;

    initial begin
        mA  = eth_metadata_t'(32'h0800_0011); mA2 = eth_metadata_t'(32'h0800_0022);
        mB  = eth_metadata_t'(32'h86DD_0031); mC  = eth_metadata_t'(32'h0806_00C1);
        mD  = eth_metadata_t'(32'h0806_00D1); mE  = eth_metadata_t'(32'h0806_00E1);
        mF  = eth_metadata_t'(32'h0806_00F1); mG  = eth_metadata_t'(32'h0806_0071);
        mH  = eth_metadata_t'(32'hDEAD_BEEF); mX  = eth_metadata_t'(32'h1234_5671);
        mB2 = eth_metadata_t'(32'h0800_0B21); mR0 = eth_metadata_t'(32'h0800_1001);
        mR1 = eth_metadata_t'(32'h0800_1011); mR2 = eth_metadata_t'(32'h0800_1021);
        mN  = eth_metadata_t'(32'h0800_0991);
        for (int i = 0; i < 4; i++) begin
            m5[i] = eth_metadata_t'(32'h0800_5000 + 32'(i));
            d5[i] = 64'hA0 + 64'(i);
        end
        pat = 24'b0110_1001_1100_0101_0011_1010;

        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        meta_in = '0; meta_valid_in = 1'b0; meta_drop_in = 1'b0; m_axis_tready = 1'b1;
        repeat (3) step();
        check("rst_s_tready",  64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid",  64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata",   m_axis_tdata, 64'd0);
        check("rst_m_meta",    64'(m_meta), 64'd0);
        check("rst_meta_full", 64'(meta_full), 64'd0);
        check("rst_overflow",  64'(meta_overflow), 64'd0);
        check("rst_drop_cnt",  64'(drop_count), 64'd0);
        rst_n = 1'b1;
        step();

        // 3-beat frame A, meta A2 pushed mid-frame, one IDLE bubble before its frame
        push(mA, 1'b0);
        s_axis_tdata = 64'h11; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        #1 check("t1_gate_idle", 64'(s_axis_tready), 64'd0);
        step();
        check("t1_ready_pass", 64'(s_axis_tready), 64'd1);
        check("t1_no_out_yet", 64'(m_axis_tvalid), 64'd0);
        step();
        check("t1_b0_valid", 64'(m_axis_tvalid), 64'd1);
        check("t1_b0_data",  m_axis_tdata, 64'h11);
        check("t1_b0_meta",  64'(m_meta), 64'(mA));
        check("t1_b0_last",  64'(m_axis_tlast), 64'd0);
        s_axis_tdata = 64'h22;
        meta_in = mA2; meta_valid_in = 1'b1;
        step();
        meta_valid_in = 1'b0;
        check("t1_b1_data", m_axis_tdata, 64'h22);
        check("t1_b1_meta", 64'(m_meta), 64'(mA));
        s_axis_tdata = 64'h33; s_axis_tlast = 1'b1;
        step();
        check("t1_b2_data", m_axis_tdata, 64'h33);
        check("t1_b2_meta", 64'(m_meta), 64'(mA));
        check("t1_b2_last", 64'(m_axis_tlast), 64'd1);
        s_axis_tdata = 64'h34;
        #1 check("t1_bubble", 64'(s_axis_tready), 64'd0);
        step();
        check("t1_after_bubble", 64'(s_axis_tready), 64'd1);
        check("t1_bubble_out",   64'(m_axis_tvalid), 64'd0);
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t1_a2_data", m_axis_tdata, 64'h34);
        check("t1_a2_meta", 64'(m_meta), 64'(mA2));
        step();
        check("t1_drain", 64'(m_axis_tvalid), 64'd0);

        // Frame waits for its metadata, released 2 cycles after the push
        s_axis_tdata = 64'h44; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 check("t2_wait_ready", 64'(s_axis_tready), 64'd0);
            step();
        end
        meta_in = mB; meta_valid_in = 1'b1;
        #1 check("t2_push_cycle", 64'(s_axis_tready), 64'd0);
        step();
        meta_valid_in = 1'b0;
        check("t2_pop_cycle", 64'(s_axis_tready), 64'd0);
        step();
        check("t2_release", 64'(s_axis_tready), 64'd1);
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t2_out_data", m_axis_tdata, 64'h44);
        check("t2_out_meta", 64'(m_meta), 64'(mB));
        step();

        // Fill the FIFO behind a pending frame, then overflow it
        push(mC, 1'b0);
        push(mD, 1'b0);
        push(mE, 1'b0);
        check("t3_not_full", 64'(meta_full), 64'd0);
        push(mF, 1'b0);
        push(mG, 1'b0);
        check("t3_full",     64'(meta_full), 64'd1);
        check("t3_no_ovf",   64'(meta_overflow), 64'd0);
        push(mH, 1'b0);
        check("t3_overflow", 64'(meta_overflow), 64'd1);
        check("t3_still_full", 64'(meta_full), 64'd1);
        send1(64'hC0, mC, "t3_c");
        send1(64'hD0, mD, "t3_d");
        send1(64'hE0, mE, "t3_e");
        send1(64'hF0, mF, "t3_f");
        send1(64'h70, mG, "t3_g");
        s_axis_tdata = 64'h80; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t3_h_never", 64'(s_axis_tready), 64'd0);
            step();
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t3_ovf_sticky", 64'(meta_overflow), 64'd1);

        // Dropped frame followed by a normal frame
        push(mX, 1'b1);
        s_axis_tdata = 64'h55; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        wait_ready("t4_drop");
        step();
        check("t4_no_out0", 64'(m_axis_tvalid), 64'd0);
        s_axis_tdata = 64'h66; s_axis_tlast = 1'b1;
        #1 check("t4_drop_ready", 64'(s_axis_tready), 64'd1);
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t4_no_out1",  64'(m_axis_tvalid), 64'd0);
        check("t4_drop_cnt", 64'(drop_count), 64'd1);
        push(mB2, 1'b0);
        send1(64'h77, mB2, "t4_b");

        // Back-to-back one-beat frames with a stalling consumer
        for (int i = 0; i < 4; i++) push(m5[i], 1'b0);
        begin
            int in_idx = 0;
            int out_idx = 0;
            logic was_stalled = 1'b0;
            logic [63:0] prev_data = '0;
            eth_metadata_t prev_meta = '0;
            logic s_hs, m_hs;
            s_axis_tdata = d5[0]; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
            for (int cyc = 0; cyc < 80 && out_idx < 4; cyc++) begin
                m_axis_tready = pat[cyc % 24];
                #1;
                s_hs = s_axis_tvalid && s_axis_tready;
                m_hs = m_axis_tvalid && m_axis_tready;
                if (was_stalled) begin
                    check("t5_hold_valid", 64'(m_axis_tvalid), 64'd1);
                    check("t5_hold_data",  m_axis_tdata, prev_data);
                    check("t5_hold_meta",  64'(m_meta), 64'(prev_meta));
                end
                if (m_hs) begin
                    check("t5_order_data", m_axis_tdata, d5[out_idx]);
                    check("t5_order_meta", 64'(m_meta), 64'(m5[out_idx]));
                    out_idx++;
                end
                was_stalled = m_axis_tvalid && !m_axis_tready;
                prev_data   = m_axis_tdata;
                prev_meta   = m_meta;
                step();
                if (s_hs) begin
                    in_idx++;
                    if (in_idx < 4) s_axis_tdata = d5[in_idx];
                    else begin
                        s_axis_tvalid = 1'b0;
                        s_axis_tlast  = 1'b0;
                    end
                end
            end
            check("t5_all_out",   64'(out_idx), 64'd4);
            check("t5_no_extra",  64'(m_axis_tvalid), 64'd0);
        end
        m_axis_tready = 1'b1;

        // Mid-frame reset with two entries queued
        push(mR0, 1'b0);
        push(mR1, 1'b0);
        push(mR2, 1'b0);
        s_axis_tdata = 64'hBB; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        wait_ready("t6_first");
        step();
        check("t6_pre_valid", 64'(m_axis_tvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    64'(m_axis_tvalid), 64'd0);
        check("t6_rst_meta_vld", 64'(m_meta_valid), 64'd0);
        check("t6_rst_data",     m_axis_tdata, 64'd0);
        check("t6_rst_meta",     64'(m_meta), 64'd0);
        check("t6_rst_ready",    64'(s_axis_tready), 64'd0);
        check("t6_rst_ovf",      64'(meta_overflow), 64'd0);
        check("t6_rst_drop_cnt", 64'(drop_count), 64'd0);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        s_axis_tdata = 64'hCC; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_fifo_empty", 64'(s_axis_tready), 64'd0);
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        push(mN, 1'b0);
        send1(64'h99, mN, "t6_new");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
